// File: rtl/uart_mon_pkg.sv
// Shared constants for the UART receive monitor: CRC-32 parameters and display source encodings.
package uart_mon_pkg;

   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DISP_CNT    = 2'd0,
      DISP_CRC_LO = 2'd1,
      DISP_CRC_HI = 2'd2,
      DISP_STAT   = 2'd3
   } disp_mode_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 (reflected) next state for one byte; zero latency, no flow control.
module crc32_byte
   import uart_mon_pkg::*;
(
   input  logic [31:0] state,
   input  logic [7:0]  data,
   output logic [31:0] next_state
);

   logic [31:0] c;

   always_comb begin
      c = state ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      next_state = c;
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: byte/error statistics, checksum, FWFT receive FIFO and 7-segment feed.
// Define UART_RX_MONITOR_CRC_EN for CRC-32 on crc_o; otherwise crc_o carries a running XOR.
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int CNT_W      = 20,
   parameter int FIFO_DEPTH = 16,
   parameter int DISP_W     = 24,
   parameter int REFRESH_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_frame_err,
   input  logic              clr,
   input  logic [1:0]        disp_mode,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              ovf,
   output logic [CNT_W-1:0]  byte_cnt,
   output logic [7:0]        ferr_cnt,
   output logic [31:0]       crc_o,
   output logic [DISP_W-1:0] disp_data,
   output logic              disp_wen,
   output logic              disp_base
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic              good, push, pop;
   logic [AW:0]       wr_ptr, rd_ptr, level;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [7:0]        last_byte;
   logic [REFRESH_W-1:0] refresh_cnt;
   logic [1:0]        mode_q;
   logic [DISP_W-1:0] disp_nxt;
   logic [63:0]       cnt_ext, stat_ext;

   assign good       = rx_valid & ~rx_frame_err;
   assign level      = wr_ptr - rd_ptr;
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
   assign pop        = rd_en & ~fifo_empty;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
   assign push       = good & (~fifo_full | pop);
   assign rd_data    = fifo_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ovf       <= 1'b0;
         byte_cnt  <= '0;
         ferr_cnt  <= '0;
         last_byte <= '0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ovf       <= 1'b0;
         byte_cnt  <= '0;
         ferr_cnt  <= '0;
         last_byte <= '0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (good && !push)
            ovf <= 1'b1;
         if (good) begin
            last_byte <= rx_data;
            if (byte_cnt != '1)
               byte_cnt <= byte_cnt + CNT_W'(1);
         end
         if (rx_valid && rx_frame_err && ferr_cnt != 8'hFF)
            ferr_cnt <= ferr_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wr_ptr[AW-1:0]] <= rx_data;
   end

`ifdef UART_RX_MONITOR_CRC_EN
   logic [31:0] crc_state, crc_next;

   crc32_byte u_crc (
      .state      (crc_state),
      .data       (rx_data),
      .next_state (crc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc_state <= CRC32_INIT;
      else if (clr)
         crc_state <= CRC32_INIT;
      else if (good)
         crc_state <= crc_next;
   end

   assign crc_o = ~crc_state;
`else
   logic [7:0] xor_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xor_q <= '0;
      else if (clr)
         xor_q <= '0;
      else if (good)
         xor_q <= xor_q ^ rx_data;
   end

   assign crc_o = {24'd0, xor_q};
`endif

   assign cnt_ext  = 64'(byte_cnt);
   assign stat_ext = 64'({ferr_cnt, last_byte, level});

   always_comb begin
      disp_nxt = '0;
      case (disp_mode_t'(disp_mode))
         DISP_CNT:    disp_nxt = cnt_ext[DISP_W-1:0];
         DISP_CRC_LO: disp_nxt = crc_o[DISP_W-1:0];
         DISP_CRC_HI: disp_nxt = crc_o[31 -: DISP_W];
         DISP_STAT:   disp_nxt = stat_ext[DISP_W-1:0];
         default:     disp_nxt = '0;
      endcase
   end

   // Counter reads 0 now means it reads 1 next cycle, aligning the pulse with count 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         mode_q      <= DISP_CNT;
         disp_data   <= '0;
         disp_wen    <= 1'b0;
         disp_base   <= 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_W'(1);
         mode_q      <= disp_mode;
         disp_data   <= disp_nxt;
         disp_wen    <= (refresh_cnt == '0) || (disp_mode != mode_q);
         disp_base   <= (disp_mode == DISP_CNT);
      end
   end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized bench for uart_rx_monitor against a queue-based reference model.
module tb_uart_rx_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_frame_err = 1'b0;
   logic        clr = 1'b0;
   logic [1:0]  disp_mode = 2'd0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_data;
   logic        fifo_empty, fifo_full, ovf;
   logic [7:0]  byte_cnt;
   logic [7:0]  ferr_cnt;
   logic [31:0] crc_o;
   logic [23:0] disp_data;
   logic        disp_wen, disp_base;

   uart_rx_monitor #(.CNT_W(8), .FIFO_DEPTH(16), .DISP_W(24), .REFRESH_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_frame_err(rx_frame_err), .clr(clr), .disp_mode(disp_mode), .rd_en(rd_en),
      .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .ovf(ovf),
      .byte_cnt(byte_cnt), .ferr_cnt(ferr_cnt), .crc_o(crc_o),
      .disp_data(disp_data), .disp_wen(disp_wen), .disp_base(disp_base)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   bit [7:0]  q[$];
   int        m_cnt, m_ferr, cyc;
   bit [31:0] m_crc_st;
   bit [7:0]  m_xor, m_last;
   bit        m_ovf;
   bit [1:0]  m_prev;
   bit [23:0] e_disp;
   bit        e_wen, e_base;
   bit [31:0] crc_tab [256];

   function automatic void build_tab();
      for (int i = 0; i < 256; i++) begin
         bit [31:0] c;
         c = i;
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[i] = c;
      end
   endfunction

   function automatic bit [31:0] exp_crc();
`ifdef UART_RX_MONITOR_CRC_EN
      return ~m_crc_st;
`else
      return {24'd0, m_xor};
`endif
   endfunction

   function automatic bit [23:0] disp_val(input bit [1:0] m);
      bit [31:0] c;
      c = exp_crc();
      case (m)
         2'd0:    return 24'(m_cnt);
         2'd1:    return c[23:0];
         2'd2:    return c[31:8];
         default: return 24'((m_ferr << 13) | (int'(m_last) << 5) | q.size());
      endcase
   endfunction

   function automatic void m_clear();
      q.delete();
      m_cnt = 0; m_ferr = 0; m_crc_st = 32'hFFFF_FFFF; m_xor = 0; m_last = 0; m_ovf = 0;
   endfunction

   // Drive one cycle of inputs at a falling edge, advance the model, return at the next falling edge.
   task automatic step(input bit v, input bit [7:0] d, input bit fe, input bit rd,
                       input bit c, input bit [1:0] m);
      rx_valid = v; rx_data = d; rx_frame_err = fe; rd_en = rd; clr = c; disp_mode = m;
      e_disp = disp_val(m);
      e_base = (m == 2'd0);
      e_wen  = (((cyc + 1) % 16) == 1) || (m != m_prev);
      m_prev = m;
      cyc++;
      if (c) m_clear();
      else begin
         if (rd && q.size() > 0) void'(q.pop_front());
         if (v && !fe) begin
            if (q.size() < 16) q.push_back(d);
            else m_ovf = 1;
            if (m_cnt < 255) m_cnt++;
            m_crc_st = (m_crc_st >> 8) ^ crc_tab[m_crc_st[7:0] ^ d];
            m_xor ^= d;
            m_last = d;
         end
         if (v && fe && m_ferr < 255) m_ferr++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit [1:0] m = 2'd0);
      step(0, 8'h00, 0, 0, 0, m);
   endtask

   task automatic do_clr();
      step(0, 8'h00, 0, 0, 1, 2'd0);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++; if (byte_cnt !== 8'd0) $display("FAIL reset byte_cnt got %h want 0", byte_cnt); else n_pass++;
      n_total++; if (ferr_cnt !== 8'd0) $display("FAIL reset ferr_cnt got %h want 0", ferr_cnt); else n_pass++;
      n_total++; if (crc_o !== 32'd0) $display("FAIL reset crc_o got %h want 0", crc_o); else n_pass++;
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL reset fifo_empty got %b want 1", fifo_empty); else n_pass++;
      n_total++; if (fifo_full !== 1'b0) $display("FAIL reset fifo_full got %b want 0", fifo_full); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL reset ovf got %b want 0", ovf); else n_pass++;
      n_total++; if (rd_data !== 8'd0) $display("FAIL reset rd_data got %h want 0", rd_data); else n_pass++;
      n_total++; if (disp_data !== 24'd0) $display("FAIL reset disp_data got %h want 0", disp_data); else n_pass++;
      n_total++; if (disp_wen !== 1'b0) $display("FAIL reset disp_wen got %b want 0", disp_wen); else n_pass++;
      n_total++; if (disp_base !== 1'b1) $display("FAIL reset disp_base got %b want 1", disp_base); else n_pass++;
      rst_n = 1'b1;
      cyc = 0; m_prev = 0;
      m_clear();
   endtask

   task automatic test_crc_vector();
      bit [31:0] want;
`ifdef UART_RX_MONITOR_CRC_EN
      want = 32'hCBF43926;
`else
      want = 32'h00000031;
`endif
      do_clr();
      for (int i = 0; i < 9; i++) step(1, 8'(8'h31 + i), 0, 0, 0, 2'd0);
      n_total++; if (crc_o !== want) $display("FAIL crc_vec crc_o got %h want %h", crc_o, want); else n_pass++;
      n_total++; if (crc_o !== exp_crc()) $display("FAIL crc_vec model crc_o got %h want %h", crc_o, exp_crc()); else n_pass++;
      n_total++; if (byte_cnt !== 8'd9) $display("FAIL crc_vec byte_cnt got %0d want 9", byte_cnt); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (rd_data !== 8'(8'h31 + i)) $display("FAIL crc_vec rd_data[%0d] got %h want %h", i, rd_data, 8'(8'h31 + i));
         else n_pass++;
         step(0, 8'h00, 0, 1, 0, 2'd0);
      end
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL crc_vec drained fifo_empty got %b want 1", fifo_empty); else n_pass++;
   endtask

   task automatic test_frame_err();
      bit [31:0] crc0;
      do_clr();
      step(1, 8'hA5, 0, 0, 0, 2'd0);
      crc0 = crc_o;
      for (int i = 0; i < 3; i++) step(1, 8'($urandom), 1, 0, 0, 2'd0);
      n_total++; if (ferr_cnt !== 8'd3) $display("FAIL ferr ferr_cnt got %0d want 3", ferr_cnt); else n_pass++;
      n_total++; if (byte_cnt !== 8'd1) $display("FAIL ferr byte_cnt got %0d want 1", byte_cnt); else n_pass++;
      n_total++; if (crc_o !== crc0) $display("FAIL ferr crc_o got %h want %h", crc_o, crc0); else n_pass++;
      n_total++; if (rd_data !== 8'hA5) $display("FAIL ferr rd_data got %h want a5", rd_data); else n_pass++;
      step(0, 8'h00, 0, 1, 0, 2'd0);
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL ferr fifo_empty got %b want 1", fifo_empty); else n_pass++;
      for (int i = 0; i < 260; i++) step(1, 8'($urandom), 1, 0, 0, 2'd0);
      n_total++; if (ferr_cnt !== 8'd255) $display("FAIL ferr_sat ferr_cnt got %0d want 255", ferr_cnt); else n_pass++;
   endtask

   task automatic test_overflow();
      do_clr();
      for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, 0, 2'd0);
      n_total++; if (fifo_full !== 1'b1 || ovf !== 1'b0) $display("FAIL ovf16 full/ovf got %b%b want 10", fifo_full, ovf); else n_pass++;
      step(1, 8'($urandom), 0, 0, 0, 2'd0);
      n_total++; if (fifo_full !== 1'b1 || ovf !== 1'b1) $display("FAIL ovf17 full/ovf got %b%b want 11", fifo_full, ovf); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (rd_data !== q[0]) $display("FAIL ovf rd_data[%0d] got %h want %h", i, rd_data, q[0]);
         else n_pass++;
         step(0, 8'h00, 0, 1, 0, 2'd0);
      end
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL ovf drained fifo_empty got %b want 1", fifo_empty); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL ovf sticky got %b want 1", ovf); else n_pass++;
   endtask

   task automatic test_full_rw();
      bit [7:0] nb;
      bit [7:0] got;
      do_clr();
      for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, 0, 2'd0);
      nb = 8'($urandom);
      step(1, nb, 0, 1, 0, 2'd0);
      n_total++; if (fifo_full !== 1'b1) $display("FAIL full_rw fifo_full got %b want 1", fifo_full); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL full_rw ovf got %b want 0", ovf); else n_pass++;
      got = 8'h00;
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (rd_data !== q[0]) $display("FAIL full_rw rd_data[%0d] got %h want %h", i, rd_data, q[0]);
         else n_pass++;
         got = rd_data;
         step(0, 8'h00, 0, 1, 0, 2'd0);
      end
      n_total++; if (got !== nb) $display("FAIL full_rw last byte got %h want %h", got, nb); else n_pass++;
   endtask

   task automatic test_saturation();
      do_clr();
      for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0, 1, 0, 2'd0);
      n_total++; if (byte_cnt !== 8'd255) $display("FAIL sat byte_cnt got %0d want 255", byte_cnt); else n_pass++;
      n_total++; if (crc_o !== exp_crc()) $display("FAIL sat crc_o got %h want %h", crc_o, exp_crc()); else n_pass++;
      step(1, 8'h5A, 0, 1, 1, 2'd0);
      n_total++; if (byte_cnt !== 8'd0) $display("FAIL clr byte_cnt got %0d want 0", byte_cnt); else n_pass++;
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL clr fifo_empty got %b want 1", fifo_empty); else n_pass++;
      n_total++; if (crc_o !== 32'd0) $display("FAIL clr crc_o got %h want 0", crc_o); else n_pass++;
   endtask

   task automatic test_random();
      bit [7:0] exp_rd;
      do_clr();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0, 2'd0);
         exp_rd = (q.size() > 0) ? q[0] : 8'h00;
         n_total++;
         if (byte_cnt !== 8'(m_cnt) || ferr_cnt !== 8'(m_ferr) || crc_o !== exp_crc() ||
             rd_data !== exp_rd || fifo_empty !== (q.size() == 0) ||
             fifo_full !== (q.size() == 16) || ovf !== m_ovf)
            $display("FAIL random[%0d] got cnt=%h ferr=%h crc=%h rd=%h e=%b f=%b o=%b want cnt=%h ferr=%h crc=%h rd=%h e=%b f=%b o=%b",
                     i, byte_cnt, ferr_cnt, crc_o, rd_data, fifo_empty, fifo_full, ovf,
                     8'(m_cnt), 8'(m_ferr), exp_crc(), exp_rd, q.size() == 0, q.size() == 16, m_ovf);
         else n_pass++;
      end
   endtask

   task automatic test_display();
      int pulses;
      do_clr();
      for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0, 2'd0);
      step(1, 8'h3C, 1, 0, 0, 2'd0);
      idle(2'd0);
      idle(2'd1);
      n_total++; if (disp_wen !== 1'b1) $display("FAIL disp mode_change wen got %b want 1", disp_wen); else n_pass++;
      n_total++; if (disp_base !== 1'b0) $display("FAIL disp mode1 base got %b want 0", disp_base); else n_pass++;
      n_total++; if (disp_data !== e_disp) $display("FAIL disp mode1 data got %h want %h", disp_data, e_disp); else n_pass++;
      pulses = 0;
      for (int i = 0; i < 48; i++) begin
         idle(2'd1);
         if (disp_wen === 1'b1) pulses++;
         n_total++;
         if (disp_wen !== e_wen || disp_data !== e_disp)
            $display("FAIL disp refresh[%0d] got wen=%b data=%h want wen=%b data=%h", i, disp_wen, disp_data, e_wen, e_disp);
         else n_pass++;
      end
      n_total++; if (pulses != 3) $display("FAIL disp period pulses got %0d want 3", pulses); else n_pass++;
      for (int m = 0; m < 4; m++) begin
         idle(2'(m));
         n_total++;
         if (disp_data !== e_disp || disp_base !== e_base || disp_wen !== e_wen)
            $display("FAIL disp mode%0d got data=%h base=%b wen=%b want data=%h base=%b wen=%b",
                     m, disp_data, disp_base, disp_wen, e_disp, e_base, e_wen);
         else n_pass++;
      end
   endtask

   initial begin
      build_tab();
      cyc = 0; m_prev = 0;
      m_clear();
      test_reset();
      test_crc_vector();
      test_frame_err();
      test_overflow();
      test_full_rw();
      test_saturation();
      test_random();
      test_display();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
